hex_scan_scheduler: RTL and testbench

- Owns the board's seven-segment displays and time-shares one internal hex-to-segment decoder across NUM_DIGITS digit slots.
- A round-robin scan, paced by a prescaler, refreshes one registered segment output per slot.
- Digit values arrive through a valid/ready write port. A scroll_step pulse rotates the digit buffer.
- Sits between lab datapaths, which produce 4-bit values, and the HEX outputs.

---
 rtl/hex_scan_scheduler.sv | 107 ++++++++++
 tb/tb_hex_scan_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_scheduler.sv
// Time-shared hex-to-seven-segment scan scheduler: one font decoder refreshes
// NUM_DIGITS registered segment slots in round-robin order, paced by a prescaler.
module hex_scan_scheduler #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2:0]              wr_idx,
  input  logic [3:0]              wr_data,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    scroll_step,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    frame_done
);

  localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [6:0]  SEG_DARK = 7'h7F;

  logic [DIV_W-1:0]       div_cnt;
  logic [IDX_W-1:0]       scan_idx;
  logic [3:0]             digit     [NUM_DIGITS];
  logic [3:0]             digit_nxt [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_nxt_c;
  logic                   tc_c;
  logic                   scan_last_c;
  logic                   accept_c;

  // Active-low font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] font(input logic [3:0] d);
    font = SEG_DARK;
    case (d)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      4'hF: font = 7'h0E;
    endcase
  endfunction

  assign tc_c        = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_last_c = (scan_idx == IDX_W'(NUM_DIGITS - 1));
  assign accept_c    = wr_valid && wr_ready;

  // Rotate first, then let an accepted write override its post-rotation slot.
  always_comb begin
    digit_nxt = digit;
    if (scroll_step) begin
      digit_nxt[0] = digit[NUM_DIGITS-1];
      for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
        digit_nxt[i] = digit[i-1];
      end
    end
    if (accept_c) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (wr_idx == 3'(i)) begin
          digit_nxt[i] = wr_data;
        end
      end
    end
  end

  // Only the slot under the scan pointer is refreshed, from pre-edge digits.
  always_comb begin
    seg_nxt_c = seg_out;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        seg_nxt_c[7*i +: 7] = blank[i] ? SEG_DARK : font(digit[i]);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      div_cnt    <= '0;
      scan_idx   <= '0;
      digit      <= '{default: '0};
      seg_out    <= {NUM_DIGITS{SEG_DARK}};
      frame_done <= 1'b0;
      wr_ready   <= 1'b1;
    end else begin
      div_cnt    <= tc_c ? '0 : div_cnt + DIV_W'(1);
      digit      <= digit_nxt;
      frame_done <= tc_c && scan_last_c;
      wr_ready   <= !accept_c;
      if (tc_c) begin
        seg_out  <= seg_nxt_c;
        scan_idx <= scan_last_c ? '0 : scan_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Self-checking bench for hex_scan_scheduler: directed scenarios plus random
// traffic, all compared against an edge-count based reference model.
module tb_hex_scan_scheduler;

  localparam int ND    = 6;
  localparam int SD    = 4;
  localparam int FRAME = ND * SD;
  localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [7*ND-1:0] ALL_DARK = {ND{7'h7F}};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_valid = 1'b0;
  logic            scroll_step = 1'b0;
  logic [2:0]      wr_idx = '0;
  logic [3:0]      wr_data = '0;
  logic [ND-1:0]   blank = '0;
  logic            wr_ready;
  logic            frame_done;
  logic [7*ND-1:0] seg_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release, digits, displayed slots.
  int         n;
  logic [3:0] m_digit [ND];
  logic [6:0] m_seg   [ND];
  logic       m_ready;
  logic       m_frame;

  hex_scan_scheduler #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DIV_W(16)) dut (
    .Clock(clk), .Resetn(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_data(wr_data), .blank(blank), .scroll_step(scroll_step),
    .seg_out(seg_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < ND; i++) begin
      m_digit[i] = 4'h0;
      m_seg[i]   = 7'h7F;
    end
    m_ready = 1'b1;
    m_frame = 1'b0;
  endtask

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    logic       acc;
    logic [3:0] old [ND];
    int         slot;
    acc = wr_valid && m_ready;
    n++;
    if (n % SD == 0) begin
      slot = (n / SD - 1) % ND;
      m_seg[slot] = blank[slot] ? 7'h7F : FONT[m_digit[slot]];
    end
    old = m_digit;
    if (scroll_step) begin
      for (int i = 0; i < ND; i++) m_digit[i] = old[(i + ND - 1) % ND];
    end
    if (acc && int'(wr_idx) < ND) m_digit[wr_idx] = wr_data;
    m_ready = !acc;
    m_frame = (n % FRAME == 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7*ND-1:0] seg_exp();
    logic [7*ND-1:0] v;
    v = '0;
    for (int i = 0; i < ND; i++) v[7*i +: 7] = m_seg[i];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (seg_out !== ALL_DARK) begin errors++; $display("FAIL reset_seg got %h want %h", seg_out, ALL_DARK); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      tick();
      checks++;
      if ({seg_out, frame_done, wr_ready} !== {seg_exp(), m_frame, m_ready}) begin
        errors++;
        $display("FAIL reset_run edge %0d got seg=%h fd=%b rdy=%b want seg=%h fd=%b rdy=%b",
                 k, seg_out, frame_done, wr_ready, seg_exp(), m_frame, m_ready);
      end
      if (k == 3) begin
        checks++;
        if (seg_out !== ALL_DARK) begin errors++; $display("FAIL dark_until_tc got %h want %h", seg_out, ALL_DARK); end
      end
      if (k == 4) begin
        checks++;
        if (seg_out[6:0] !== 7'h40) begin errors++; $display("FAIL slot0_first_scan got %h want 40", seg_out[6:0]); end
      end
      if (k == 24 || k == 48) begin
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse edge %0d got %b want 1", k, frame_done); end
      end
      if (k == 25) begin
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b want 0", frame_done); end
      end
    end
  endtask

  task automatic test_write();
    wr_valid = 1'b1; wr_idx = 3'd2; wr_data = 4'hA;
    tick();
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL write_ready_drop got %b want 0", wr_ready); end
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL write_ready_return got %b want 1", wr_ready); end
    wr_valid = 1'b0;
    repeat (FRAME) begin
      tick();
      checks++;
      if ({seg_out, frame_done, wr_ready} !== {seg_exp(), m_frame, m_ready}) begin
        errors++;
        $display("FAIL write_run got seg=%h fd=%b rdy=%b want seg=%h fd=%b rdy=%b",
                 seg_out, frame_done, wr_ready, seg_exp(), m_frame, m_ready);
      end
    end
    checks++;
    if ({seg_out[20:14], seg_out[6:0]} !== {7'h08, 7'h40}) begin
      errors++; $display("FAIL write_slot2 got %h/%h want 08/40", seg_out[20:14], seg_out[6:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] acc_mask;
    int         idx_tab [6] = '{7, 7, 1, 1, 4, 4};
    acc_mask = '0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_idx = 3'(idx_tab[i]); wr_data = 4'(i + 3);
      acc_mask[i] = wr_ready;
      tick();
      checks++;
      if ({seg_out, frame_done, wr_ready} !== {seg_exp(), m_frame, m_ready}) begin
        errors++;
        $display("FAIL b2b_run got seg=%h fd=%b rdy=%b want seg=%h fd=%b rdy=%b",
                 seg_out, frame_done, wr_ready, seg_exp(), m_frame, m_ready);
      end
    end
    wr_valid = 1'b0;
    checks++;
    if (acc_mask !== 6'b010101) begin errors++; $display("FAIL b2b_accepts got %b want 010101", acc_mask); end
    repeat (FRAME) begin
      tick();
      checks++;
      if ({seg_out, frame_done, wr_ready} !== {seg_exp(), m_frame, m_ready}) begin
        errors++;
        $display("FAIL b2b_frame got seg=%h fd=%b rdy=%b want seg=%h fd=%b rdy=%b",
                 seg_out, frame_done, wr_ready, seg_exp(), m_frame, m_ready);
      end
    end
    checks++;
    if ({seg_out[27:21], seg_out[6:0]} !== {7'h40, 7'h40}) begin
      errors++; $display("FAIL b2b_idx7_discard got %h/%h want 40/40", seg_out[27:21], seg_out[6:0]);
    end
  endtask

  task automatic test_scroll();
    for (int i = 0; i < ND; i++) begin
      wr_valid = 1'b1; wr_idx = 3'(i); wr_data = 4'(i + 1);
      tick();
      wr_valid = 1'b0;
      tick();
    end
    scroll_step = 1'b1;
    tick();
    scroll_step = 1'b0;
    repeat (FRAME) begin
      tick();
      checks++;
      if ({seg_out, frame_done, wr_ready} !== {seg_exp(), m_frame, m_ready}) begin
        errors++;
        $display("FAIL scroll_run got seg=%h fd=%b rdy=%b want seg=%h fd=%b rdy=%b",
                 seg_out, frame_done, wr_ready, seg_exp(), m_frame, m_ready);
      end
    end
    checks++;
    if (seg_out !== {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h02}) begin
      errors++; $display("FAIL scroll_result got %h want %h", seg_out, {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h02});
    end
  endtask

  task automatic test_scroll_write();
    wr_valid = 1'b1; wr_idx = 3'd0; wr_data = 4'hF; scroll_step = 1'b1;
    tick();
    wr_valid = 1'b0; scroll_step = 1'b0;
    repeat (FRAME + 1) begin
      tick();
      checks++;
      if ({seg_out, frame_done, wr_ready} !== {seg_exp(), m_frame, m_ready}) begin
        errors++;
        $display("FAIL scroll_write_run got seg=%h fd=%b rdy=%b want seg=%h fd=%b rdy=%b",
                 seg_out, frame_done, wr_ready, seg_exp(), m_frame, m_ready);
      end
    end
    checks++;
    if (seg_out !== {7'h19, 7'h30, 7'h24, 7'h79, 7'h02, 7'h0E}) begin
      errors++; $display("FAIL scroll_write_result got %h want %h", seg_out, {7'h19, 7'h30, 7'h24, 7'h79, 7'h02, 7'h0E});
    end
  endtask

  task automatic test_blank();
    repeat (5) tick();
    blank[3] = 1'b1;
    repeat (FRAME) tick();
    checks++;
    if (seg_out[27:21] !== 7'h7F) begin errors++; $display("FAIL blank_on got %h want 7f", seg_out[27:21]); end
    blank[3] = 1'b0;
    repeat (FRAME) begin
      tick();
      checks++;
      if ({seg_out, frame_done, wr_ready} !== {seg_exp(), m_frame, m_ready}) begin
        errors++;
        $display("FAIL blank_run got seg=%h fd=%b rdy=%b want seg=%h fd=%b rdy=%b",
                 seg_out, frame_done, wr_ready, seg_exp(), m_frame, m_ready);
      end
    end
    checks++;
    if (seg_out[27:21] !== 7'h24) begin errors++; $display("FAIL blank_off got %h want 24", seg_out[27:21]); end
  endtask

  task automatic test_async_reset();
    while ((n + 1) % FRAME != 0) tick();
    wr_valid = 1'b1; wr_idx = 3'd1; wr_data = 4'h9;
    tick();
    wr_valid = 1'b0;
    checks++;
    if ({frame_done, wr_ready} !== 2'b10) begin
      errors++; $display("FAIL pre_reset_state got fd=%b rdy=%b want fd=1 rdy=0", frame_done, wr_ready);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({seg_out, frame_done, wr_ready} !== {ALL_DARK, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got seg=%h fd=%b rdy=%b want seg=%h fd=0 rdy=1", seg_out, frame_done, wr_ready, ALL_DARK);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 1; k <= FRAME + 2; k++) begin
      tick();
      checks++;
      if ({seg_out, frame_done, wr_ready} !== {seg_exp(), m_frame, m_ready}) begin
        errors++;
        $display("FAIL post_reset_run edge %0d got seg=%h fd=%b rdy=%b want seg=%h fd=%b rdy=%b",
                 k, seg_out, frame_done, wr_ready, seg_exp(), m_frame, m_ready);
      end
      if (k == 8) begin
        checks++;
        if (seg_out[13:7] !== 7'h40) begin errors++; $display("FAIL post_reset_cleared got %h want 40", seg_out[13:7]); end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      wr_valid    = 1'($urandom_range(0, 1));
      wr_idx      = 3'($urandom_range(0, 7));
      wr_data     = 4'($urandom_range(0, 15));
      scroll_step = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) blank = ND'($urandom);
      tick();
      checks++;
      if ({seg_out, frame_done, wr_ready} !== {seg_exp(), m_frame, m_ready}) begin
        errors++;
        $display("FAIL random edge %0d got seg=%h fd=%b rdy=%b want seg=%h fd=%b rdy=%b",
                 k, seg_out, frame_done, wr_ready, seg_exp(), m_frame, m_ready);
      end
    end
    wr_valid = 1'b0; scroll_step = 1'b0; blank = '0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_scroll();
    test_scroll_write();
    test_blank();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
